// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_store_sel;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  mem_address, mem_write, mem_read, mem_wdata, mem_store_sel
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output mem_address, mem_write, mem_read, mem_wdata, mem_store_sel
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer splitting misaligned accesses into byte beats
module load_store_unit (
    input  logic             clk_in,
    input  logic             rst_in,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic [1:0]  beat, beat_next;
    logic        op_write;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [31:0] asm_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        req_legal;
    logic        op_misaligned;
    logic        last_beat;
    logic [1:0]  beat_last;
    logic [31:0] beat_addr;
    logic [7:0]  lane_byte;
    logic [31:0] asm_next;
    logic [31:0] raw_load;
    logic [31:0] ext_load;

    always_comb begin
        if (bus.req_write)
            req_legal = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'd3);
        else
            req_legal = (bus.req_funct3[1:0] != 2'd3) && (bus.req_funct3 != 3'd6);
    end

    always_comb begin
        op_misaligned = ((op_funct3[1:0] == 2'd1) && op_addr[0]) ||
                        ((op_funct3[1:0] == 2'd2) && (op_addr[1:0] != 2'd0));
        if (!op_misaligned)
            beat_last = 2'd0;
        else if (op_funct3[1:0] == 2'd1)
            beat_last = 2'd1;
        else
            beat_last = 2'd3;
        last_beat = (beat == beat_last);
        // byte beats walk upward and wrap naturally at 2^32
        beat_addr = op_misaligned ? op_addr + {30'd0, beat} : op_addr;
    end

    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = 32'd0;
        bus.mem_wdata     = 32'd0;
        bus.mem_store_sel = 3'd0;
        if (state == ACCESS) begin
            bus.mem_read    = !op_write;
            bus.mem_write   = op_write;
            bus.mem_address = beat_addr;
            if (op_misaligned) begin
                bus.mem_store_sel = 3'd0;
                bus.mem_wdata     = {24'd0, op_wdata[{beat, 3'b000} +: 8]};
            end else begin
                bus.mem_store_sel = {1'b0, op_funct3[1:0]};
                bus.mem_wdata     = op_wdata;
            end
        end
    end

    always_comb begin
        lane_byte = bus.mem_rdata[{beat_addr[1:0], 3'b000} +: 8];
        asm_next = asm_q;
        asm_next[{beat, 3'b000} +: 8] = lane_byte;
        if (op_misaligned) begin
            raw_load = asm_next;
        end else begin
            case (op_funct3[1:0])
                2'd0:    raw_load = {24'd0, lane_byte};
                2'd1:    raw_load = {16'd0, bus.mem_rdata[{op_addr[1], 4'b0000} +: 16]};
                default: raw_load = bus.mem_rdata;
            endcase
        end
        case (op_funct3)
            3'd0:    ext_load = {{24{raw_load[7]}}, raw_load[7:0]};
            3'd1:    ext_load = {{16{raw_load[15]}}, raw_load[15:0]};
            3'd4:    ext_load = {24'd0, raw_load[7:0]};
            3'd5:    ext_load = {16'd0, raw_load[15:0]};
            default: ext_load = raw_load;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            beat  <= 2'd0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    always_comb begin
        state_next = state;
        beat_next  = beat;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = req_legal ? ACCESS : RESP;
                    beat_next  = 2'd0;
                end
            end
            ACCESS: begin
                if (last_beat) begin
                    state_next = RESP;
                    beat_next  = 2'd0;
                end else begin
                    beat_next = beat + 2'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            op_write     <= 1'b0;
            op_funct3    <= 3'd0;
            op_addr      <= 32'd0;
            op_wdata     <= 32'd0;
            asm_q        <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_write  <= bus.req_write;
                        op_funct3 <= bus.req_funct3;
                        op_addr   <= bus.req_addr;
                        op_wdata  <= bus.req_wdata;
                        asm_q     <= 32'd0;
                        if (!req_legal) begin
                            resp_rdata_q <= 32'd0;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    asm_q <= asm_next;
                    if (last_beat) begin
                        resp_rdata_q <= op_write ? 32'd0 : ext_load;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE) && !rst_in;
    assign bus.resp_valid = (state == RESP);
    assign bus.busy       = (state != IDLE);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    logic [31:0] mem [0:1023];
    logic [7:0]  ref_mem [0:4095];
    int errors = 0;
    int checks = 0;

    assign bus.mem_rdata = mem[bus.mem_address[11:2]];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            case (bus.mem_store_sel)
                3'd0: mem[bus.mem_address[11:2]][{bus.mem_address[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
                3'd1: mem[bus.mem_address[11:2]][{bus.mem_address[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
                default: mem[bus.mem_address[11:2]] <= bus.mem_wdata;
            endcase
        end
    end

    logic [31:0] obs_addr[$];
    logic [31:0] obs_wd[$];
    logic [2:0]  obs_sel[$];
    logic        obs_rd[$];
    logic        obs_wr[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_wd[$];
    logic [2:0]  exp_sel[$];
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;
    int          ready_bad;
    int          leak;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
        int x;
        case (f3)
            3'd0: begin x = int'(v[7:0]);  if (x > 127)   x -= 256;   end
            3'd1: begin x = int'(v[15:0]); if (x > 32767) x -= 65536; end
            3'd4: x = int'(v[7:0]);
            3'd5: x = int'(v[15:0]);
            default: x = int'(v);
        endcase
        return x;
    endfunction

    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] er, output logic ee, output int elat);
        int size;
        logic mis;
        logic [31:0] ai;
        logic [31:0] v;
        exp_addr.delete(); exp_wd.delete(); exp_sel.delete();
        er = 0; ee = 0; elat = 1;
        if (w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) begin
            ee = 1;
            return;
        end
        size = 1 << f3[1:0];
        mis = (a % size) != 0;
        elat = mis ? 1 + size : 2;
        v = 0;
        for (int i = 0; i < size; i++) begin
            ai = a + i;
            if (mis) begin
                exp_addr.push_back(ai); exp_sel.push_back(3'd0); exp_wd.push_back({24'd0, d[8*i +: 8]});
            end
            if (w) ref_mem[ai[11:0]] = d[8*i +: 8];
            else   v[8*i +: 8] = ref_mem[ai[11:0]];
        end
        if (!mis) begin
            exp_addr.push_back(a); exp_sel.push_back({1'b0, f3[1:0]}); exp_wd.push_back(d);
        end
        if (!w) er = extend(f3, v);
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        obs_addr.delete(); obs_wd.delete(); obs_sel.delete(); obs_rd.delete(); obs_wr.delete();
        got_lat = -1; ready_bad = 0; leak = 0; got_rdata = 'x; got_err = 'x;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.req_ready) ready_bad++;
            if (bus.mem_read || bus.mem_write) begin
                obs_addr.push_back(bus.mem_address); obs_wd.push_back(bus.mem_wdata);
                obs_sel.push_back(bus.mem_store_sel); obs_rd.push_back(bus.mem_read); obs_wr.push_back(bus.mem_write);
            end
            if (bus.resp_valid) begin
                got_lat = k; got_rdata = bus.resp_rdata; got_err = bus.resp_err;
                if (bus.mem_read || bus.mem_write || bus.mem_address != 0 || bus.mem_wdata != 0 || bus.mem_store_sel != 0)
                    leak++;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
        checks++; if ({bus.busy, bus.resp_valid, bus.resp_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.resp_valid, bus.resp_err}); end
        checks++; if (bus.resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
        checks++; if ({bus.mem_read, bus.mem_write, bus.mem_store_sel} !== 5'd0 || bus.mem_address !== 0 || bus.mem_wdata !== 0) begin
            errors++; $display("FAIL reset_mem: got rd=%b wr=%b addr=%h wd=%h sel=%0d want all 0", bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata, bus.mem_store_sel); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release: got ready=%b busy=%b want 1 0", bus.req_ready, bus.busy); end
    endtask

    task automatic test_aligned;
        logic [31:0] er; logic ee; int el;
        logic [31:0] t_addr[4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [2:0]  t_f3[4]   = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] t_exp[4]  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        model(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, er, ee, el);
        issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        checks++; if (got_lat !== 2 || got_err !== 1'b0 || got_rdata !== 32'd0) begin errors++; $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h want 2 0 0", got_lat, got_err, got_rdata); end
        checks++; if (obs_addr.size() != 1 || obs_addr[0] !== 32'h100 || obs_sel[0] !== 3'd2 || obs_wd[0] !== 32'hDEADBEEF || obs_wr[0] !== 1'b1 || obs_rd[0] !== 1'b0) begin
            errors++; $display("FAIL sw_beat: got n=%0d addr=%h sel=%0d wd=%h want 1 100 2 deadbeef", obs_addr.size(), obs_addr[0], obs_sel[0], obs_wd[0]); end
        model(1'b0, 3'd2, 32'h100, 32'd0, er, ee, el);
        issue(1'b0, 3'd2, 32'h100, 32'd0);
        checks++; if (got_lat !== 2 || got_rdata !== 32'hDEADBEEF || got_rdata !== er) begin errors++; $display("FAIL lw_100: got lat=%0d rdata=%h want 2 deadbeef", got_lat, got_rdata); end
        checks++; if (obs_rd.size() != 1 || obs_rd[0] !== 1'b1 || obs_wr[0] !== 1'b0 || ready_bad != 0 || leak != 0) begin
            errors++; $display("FAIL lw_beat: got n=%0d ready_bad=%0d leak=%0d want 1 0 0", obs_rd.size(), ready_bad, leak); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL resp_pulse_hold: got valid=%b rdata=%h want 0 deadbeef", bus.resp_valid, bus.resp_rdata); end
        for (int i = 0; i < 4; i++) begin
            model(1'b0, t_f3[i], t_addr[i], 32'd0, er, ee, el);
            issue(1'b0, t_f3[i], t_addr[i], 32'd0);
            checks++; if (got_rdata !== t_exp[i] || got_rdata !== er || got_lat !== 2) begin
                errors++; $display("FAIL ext_load_%0d: got rdata=%h lat=%0d want %h 2", i, got_rdata, got_lat, t_exp[i]); end
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] er; logic ee; int el;
        logic [7:0] t_b[4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        model(1'b1, 3'd2, 32'h105, 32'h11223344, er, ee, el);
        issue(1'b1, 3'd2, 32'h105, 32'h11223344);
        checks++; if (obs_addr.size() != 4 || got_lat !== 5) begin errors++; $display("FAIL sw_mis_beats: got n=%0d lat=%0d want 4 5", obs_addr.size(), got_lat); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++; if (obs_addr[i] !== 32'h105 + i || obs_wd[i] !== {24'd0, t_b[i]} || obs_sel[i] !== 3'd0 || obs_wr[i] !== 1'b1) begin
                errors++; $display("FAIL sw_mis_beat%0d: got addr=%h wd=%h sel=%0d want %h %h 0", i, obs_addr[i], obs_wd[i], obs_sel[i], 32'h105 + i, t_b[i]); end
        end
        model(1'b0, 3'd2, 32'h105, 32'd0, er, ee, el);
        issue(1'b0, 3'd2, 32'h105, 32'd0);
        checks++; if (got_rdata !== 32'h11223344 || got_rdata !== er || got_lat !== 5 || obs_rd.size() != 4) begin
            errors++; $display("FAIL lw_mis: got rdata=%h lat=%0d n=%0d want 11223344 5 4", got_rdata, got_lat, obs_rd.size()); end
        model(1'b0, 3'd5, 32'h107, 32'd0, er, ee, el);
        issue(1'b0, 3'd5, 32'h107, 32'd0);
        checks++; if (got_rdata !== 32'h00001122 || got_rdata !== er || got_lat !== 3) begin
            errors++; $display("FAIL lhu_mis: got rdata=%h lat=%0d want 00001122 3", got_rdata, got_lat); end
    endtask

    task automatic test_illegal;
        issue(1'b0, 3'd3, 32'h100, 32'd0);
        checks++; if (got_lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'd0) begin errors++; $display("FAIL illegal_load: got lat=%0d err=%b rdata=%h want 1 1 0", got_lat, got_err, got_rdata); end
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL illegal_load_mem: got %0d beats want 0", obs_addr.size()); end
        issue(1'b1, 3'd5, 32'h100, 32'h12345678);
        checks++; if (got_lat !== 1 || got_err !== 1'b1 || obs_addr.size() != 0) begin errors++; $display("FAIL illegal_store: got lat=%0d err=%b n=%0d want 1 1 0", got_lat, got_err, obs_addr.size()); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] er; logic ee; int el;
        logic saw_resp;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd2; bus.req_addr = 32'h105; bus.req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h107) begin errors++; $display("FAIL mid_third_beat: got wr=%b addr=%h want 1 107", bus.mem_write, bus.mem_address); end
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_async_drop: got wr=%b busy=%b ready=%b want 0 0 0", bus.mem_write, bus.busy, bus.req_ready); end
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) saw_resp = 1'b1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid) saw_resp = 1'b1;
        end
        checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL mid_no_resp: got resp_valid seen=%b want 0", saw_resp); end
        ref_mem[12'h105] = 8'hDD;
        ref_mem[12'h106] = 8'hCC;
        model(1'b0, 3'd2, 32'h104, 32'd0, er, ee, el);
        issue(1'b0, 3'd2, 32'h104, 32'd0);
        checks++; if (got_rdata !== er || got_rdata[15:8] !== 8'hDD || got_rdata[23:16] !== 8'hCC || got_rdata[31:24] !== 8'h22) begin
            errors++; $display("FAIL mid_lw104: got %h want %h", got_rdata, er); end
        model(1'b0, 3'd2, 32'h108, 32'd0, er, ee, el);
        issue(1'b0, 3'd2, 32'h108, 32'd0);
        checks++; if (got_rdata !== er || got_rdata[7:0] !== 8'h11) begin errors++; $display("FAIL mid_lw108: got %h want %h", got_rdata, er); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] er; logic ee; int el;
        logic want_ready, want_resp, want_beat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd1; bus.req_addr = 32'hFFFFFFFF; bus.req_wdata = 32'h0000A1B2;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) bus.req_valid = 1'b0;
            want_ready = (k == 4) || (k >= 8);
            want_resp  = (k == 3) || (k == 7);
            want_beat  = (k == 1) || (k == 2) || (k == 5) || (k == 6);
            checks++; if (bus.req_ready !== want_ready || bus.resp_valid !== want_resp || bus.mem_write !== want_beat) begin
                errors++; $display("FAIL b2b_cycle%0d: got ready=%b resp=%b wr=%b want %b %b %b", k, bus.req_ready, bus.resp_valid, bus.mem_write, want_ready, want_resp, want_beat); end
            if (want_beat) begin
                checks++; if (bus.mem_address !== ((k % 2) ? 32'hFFFFFFFF : 32'h0) || bus.mem_wdata !== ((k % 2) ? 32'hB2 : 32'hA1)) begin
                    errors++; $display("FAIL b2b_beat%0d: got addr=%h wd=%h", k, bus.mem_address, bus.mem_wdata); end
            end
        end
        ref_mem[12'hFFF] = 8'hB2;
        ref_mem[12'h000] = 8'hA1;
        model(1'b0, 3'd5, 32'hFFFFFFFF, 32'd0, er, ee, el);
        issue(1'b0, 3'd5, 32'hFFFFFFFF, 32'd0);
        checks++; if (got_rdata !== 32'h0000A1B2 || got_rdata !== er || got_lat !== 3) begin
            errors++; $display("FAIL wrap_lhu: got %h lat=%0d want 0000a1b2 3", got_rdata, got_lat); end
    endtask

    task automatic test_random;
        logic [31:0] er; logic ee; int el;
        logic w; logic [2:0] f3; logic [31:0] a; logic [31:0] d;
        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom;
            d  = $urandom;
            model(w, f3, a, d, er, ee, el);
            issue(w, f3, a, d);
            checks++; if (got_err !== ee || got_rdata !== er || got_lat !== el) begin
                errors++; $display("FAIL rnd%0d_resp: w=%b f3=%0d a=%h got err=%b rdata=%h lat=%0d want %b %h %0d", n, w, f3, a, got_err, got_rdata, got_lat, ee, er, el); end
            checks++; if (obs_addr.size() != (ee ? 0 : exp_addr.size()) || ready_bad != 0 || leak != 0) begin
                errors++; $display("FAIL rnd%0d_beats: got n=%0d ready_bad=%0d leak=%0d want %0d 0 0", n, obs_addr.size(), ready_bad, leak, ee ? 0 : exp_addr.size()); end
            if (!ee) begin
                for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                    checks++; if (obs_addr[i] !== exp_addr[i] || obs_sel[i] !== exp_sel[i] || obs_wr[i] !== w || obs_rd[i] !== !w || (w && obs_wd[i] !== exp_wd[i])) begin
                        errors++; $display("FAIL rnd%0d_beat%0d: got addr=%h sel=%0d wd=%h want %h %0d %h", n, i, obs_addr[i], obs_sel[i], obs_wd[i], exp_addr[i], exp_sel[i], exp_wd[i]); end
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = mem[i][8*b +: 8];
        end
        test_reset();
        test_aligned();
        test_misaligned();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store sequencer between the execute stage and the data memory. Accepts one RV32I load or store per handshake and drives the data memory port. Aligned accesses use one memory cycle. Misaligned halfword/word accesses are split into per-byte beats. Load results are sign- or zero-extended and returned with a one-cycle valid pulse.

## Interface
- No parameters; all widths are fixed RV32I (32-bit address/data, 3-bit funct3).
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE and only while rst_in is low.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; the response has no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; set for an illegal funct3.
- busy  out  1  state is not IDLE.
- mem_address  out  32  to data memory address.
- mem_write  out  1  to data memory write enable.
- mem_read  out  1  to data memory read enable.
- mem_wdata  out  32  to data memory write data.
- mem_store_sel  out  3  to data memory store select.
- mem_rdata  in  32  from data memory; combinational read of the word at mem_address[11:2].

## Operation
- **Handshake:** a request is accepted at a rising edge where req_valid and req_ready are both high. All request fields are latched at that edge.
- **Illegal funct3:**
  - Loads: 3, 6, 7. Stores: greater than 2.
  - IDLE goes directly to RESP with resp_err=1 and resp_rdata=0.
  - No memory cycle is issued.
- **Aligned access:** byte accesses are always aligned; a half is aligned when addr[0]=0; a word is aligned when addr[1:0]=0.
  - One ACCESS beat with mem_address=addr and mem_store_sel=funct3[1:0] zero-extended.
  - mem_wdata = req_wdata.
- **Misaligned access:** a half with addr[0]=1, or a word with addr[1:0]≠0.
  - N byte beats, N=2 for a half and N=4 for a word.
  - Beat i uses mem_address = addr+i (mod 2^32), mem_store_sel=0, mem_wdata = {24'b0, wdata byte i}.
- **Load capture:** mem_read=1 during every beat. mem_rdata is sampled at the rising edge that ends the beat.
  - Aligned byte: lane addr[1:0].
  - Aligned half: lanes {addr[1],1}:{addr[1],0}.
  - Beat i of a misaligned access: lane (addr+i)[1:0] goes into byte i of the assembly register.
- **Store commit:** mem_write=1 during every store beat; the memory commits at the edge that ends the beat.
- **Extension:** LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
- **States:**
  - IDLE → ACCESS on an accepted legal request; IDLE → RESP on an accepted illegal request.
  - ACCESS holds a beat counter 0..N-1 and goes to RESP after the last beat.
  - RESP → IDLE unconditionally.
- **Memory outputs outside ACCESS:** mem_read, mem_write, mem_address, mem_wdata and mem_store_sel are all 0.
- **resp_rdata/resp_err:** held until the next response.

## Timing
- Request accepted at edge T, with ACCESS starting in the cycle after T:
  - Aligned: resp_valid in cycle T+2.
  - Misaligned: resp_valid in cycle T+1+N.
  - Illegal: resp_valid in cycle T+1.
- req_ready is low from the accept edge until RESP has passed. The next request can be accepted no earlier than the first IDLE cycle after RESP.
- **Reset values:**
  - state IDLE, beat counter 0.
  - req_ready 0 while rst_in is high, 1 afterwards.
  - resp_valid, resp_rdata, resp_err, busy and all mem_* outputs 0.
- **Reset mid-operation:** remaining beats are aborted immediately and mem_write drops asynchronously. No response is generated. Store beats already committed stay in memory; partial stores are permitted.
- **Address wrap-around:** addr+i wraps mod 2^32; e.g. a half at 0xFFFFFFFF uses 0xFFFFFFFF then 0x00000000.

## Test plan
1. SW 0x100 data 0xDEADBEEF, then LW 0x100 → resp_rdata 0xDEADBEEF.
   - Each access has one mem beat.
   - resp_valid arrives 2 cycles after accept.
2. After (1): LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE; LH 0x102 → 0xFFFFDEAD; LHU 0x100 → 0x0000BEEF.
3. SW 0x105 data 0x11223344 →
   - 4 beats at addresses 0x105, 0x106, 0x107, 0x108 with mem_wdata[7:0] = 44, 33, 22, 11.
   - Then LW 0x105 → 0x11223344, with resp_valid 5 cycles after accept.
   - Then LHU 0x107 → 0x00001122.
4. Load with funct3=3 → resp_valid and resp_err=1 one cycle after accept, resp_rdata=0, mem_read and mem_write never asserted.
5. Start SW 0x105 data 0xAABBCCDD, then assert rst_in after the 2nd beat →
   - mem_write drops at once and no resp_valid is produced.
   - Then LW 0x104 → bytes at 0x105=DD and 0x106=CC; bytes at 0x104 and 0x107 are unchanged.
   - Then LW 0x108 → byte at 0x108 unchanged.
6. Hold req_valid high for two back-to-back SH at 0xFFFFFFFF data 0xA1B2 →
   - req_ready is low while busy.
   - Each request uses beats at 0xFFFFFFFF then 0x00000000, carrying B2 then A1.
   - The second request is accepted only after the first response's RESP cycle.
